// File: rtl/oam_dma.sv
// OAM DMA engine behind register 0xFF46: copies OAM_BYTES bytes from page {src_page,00} into OAM.
// Optional build macro OAM_DMA_ECHO_CLAMP_EN folds source pages E0-FF onto the C0-DF echo of WRAM.
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int OAM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data_w,
  input  logic        write_enable,
  output logic [7:0]  data_r,
  output logic        data_active,
  output logic        bus_active,
  output logic [15:0] bus_addr,
  input  logic [7:0]  bus_data_r,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  localparam logic [3:0] LAST_PHASE = 4'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  src_page;
  logic [7:0]  idx;
  logic [3:0]  phase;
  logic        trigger;
  logic        byte_done;

  function automatic logic [7:0] map_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_CLAMP_EN
    return (page >= 8'hE0) ? page - 8'h20 : page;
`else
    return page;
`endif
  endfunction

  assign trigger     = write_enable && (addr == 16'hFF46);
  assign byte_done   = (state == XFER) && (phase == LAST_PHASE);
  assign data_active = !write_enable && (addr == 16'hFF46);
  assign bus_active  = (state != IDLE);
  assign bus_addr    = (state == XFER) ? {src_page, idx} : 16'h0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new trigger always wins over the end-of-transfer return to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      START:   if (phase == LAST_PHASE) state_next = XFER;
      XFER:    if (byte_done && (idx == LAST_IDX)) state_next = IDLE;
      default: state_next = state;
    endcase
    if (trigger) state_next = START;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_page <= 8'h00;
      idx      <= 8'h00;
      phase    <= 4'h0;
      data_r   <= 8'hFF;
      oam_we   <= 1'b0;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
    end else begin
      oam_we <= 1'b0;
      // The completing byte is written even if a retrigger lands on the same edge.
      if (byte_done) begin
        oam_we   <= 1'b1;
        oam_addr <= idx;
        oam_data <= bus_data_r;
      end
      if (trigger) begin
        data_r   <= data_w;
        src_page <= map_page(data_w);
        idx      <= 8'h00;
        phase    <= 4'h0;
      end else begin
        case (state)
          START: begin
            phase <= (phase == LAST_PHASE) ? 4'h0 : phase + 4'd1;
          end
          XFER: begin
            phase <= (phase == LAST_PHASE) ? 4'h0 : phase + 4'd1;
            if (byte_done) idx <= (idx == LAST_IDX) ? 8'h00 : idx + 8'd1;
          end
          default: begin
            phase <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

- OAM DMA engine, I/O register 0xFF46; sits upstream of the cartridge, WRAM and VRAM slaves on the memory bus.
- A CPU write of a source page `XX` copies 160 bytes from `XX00–XX9F` into OAM (`FE00–FE9F`).
- While running it owns the bus address: the bus arbiter muxes `bus_addr` onto the slaves, including cart ROM/EXTRAM, and returns their read data on `bus_data_r`.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, default 4: clocks per transferred byte (one M-cycle); legal range 2–16.
- `OAM_BYTES`, default 160: bytes per transfer.

Ports (one clock; reset is synchronous and active-high):
- `clk  in  1`: system clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `addr  in  16`: CPU bus address.
- `data_w  in  8`: CPU write data.
- `write_enable  in  1`: CPU write strobe.
- `data_r  out  8`: register readback (last written page).
- `data_active  out  1`: high when `!write_enable && addr == 16'hFF46`.
- `bus_active  out  1`: DMA owns the bus; the arbiter selects `bus_addr`.
- `bus_addr  out  16`: source address `{src_page, idx}`.
- `bus_data_r  in  8`: read data from the selected slave.
- `oam_we  out  1`: OAM write strobe, one-cycle pulse.
- `oam_addr  out  8`: OAM byte index, 0–159.
- `oam_data  out  8`: OAM write data.

## Operation
States are IDLE, START and XFER.

Registers:
- `src_page` (8 bit)
- `idx` (8 bit)
- `phase` (4 bit, 0..`CYCLES_PER_BYTE`-1)
- `data_r` (8 bit)

Reset values:
- State = IDLE; `src_page` = 0; `idx` = 0; `phase` = 0; `data_r` = 8'hFF.
- `oam_we` = 0, `oam_addr` = 0, `oam_data` = 0.
- `bus_active` = 0; `bus_addr` = 16'h0000 while idle.

Trigger:
- Condition: `write_enable && addr == 16'hFF46` at a rising edge, in any state.
- Actions: `data_r` <= `data_w`; `src_page` <= `data_w` (see Configuration); `idx` <= 0; `phase` <= 0; state <= START.
- A trigger during START or XFER restarts the transfer from index 0 with the new page. Bytes already written stay in OAM.

START:
- Lasts `CYCLES_PER_BYTE` cycles with `bus_active` = 1 and no OAM write.
- When `phase` reaches `CYCLES_PER_BYTE`-1: state <= XFER, `phase` <= 0.

XFER:
- `bus_addr` = `{src_page, idx}`, held stable for the whole byte period.
- At the edge ending `phase` = `CYCLES_PER_BYTE`-1:
  - `oam_data` <= `bus_data_r`; `oam_addr` <= `idx`; `oam_we` <= 1 for exactly one cycle.
  - If `idx` = `OAM_BYTES`-1: state <= IDLE, `idx` <= 0. Otherwise `idx` <= `idx`+1.
- `phase` wraps to 0 after each byte.

Other rules:
- `bus_active` = (state != IDLE), decoded combinationally from registered state.
- `data_active` is combinational and does not depend on DMA state.
- Reset mid-transfer returns to IDLE on that edge and suppresses any pending `oam_we`.
- A simultaneous trigger and final-byte completion: the trigger wins. State goes to START; the completing byte is still written (`oam_we` pulses).

## Timing
- Write sampled at edge T0. `bus_active` rises after T0 and stays high for (`OAM_BYTES`+1)·`CYCLES_PER_BYTE` cycles: 644 at defaults.
- Byte i is addressed from cycle T0+(i+1)·P+1 for P cycles, where P = `CYCLES_PER_BYTE`.
- `oam_we` for byte i is high in the cycle after its period ends.
- The last `oam_we` falls one cycle after `bus_active` drops.
- Slaves must present `bus_data_r` no later than the last phase of each byte. The cart's negedge-registered read data satisfies this for P ≥ 2.

## Configuration
- Macro `OAM_DMA_ECHO_CLAMP_EN`.
- Defined: trigger pages 8'hE0–8'hFF are stored as page−8'h20, so E0–FD map onto the C0–DD echo and FE/FF fold onto DE/DF. Pages below E0 are stored unchanged.
- Undefined: `src_page` = `data_w` unmodified; pages FE/FF read OAM/IO as-is.
- `data_r` always returns the unmodified written value.

## Test plan
- Reset, then idle: `bus_active`=0, `oam_we`=0, read of FF46 gives `data_active`=1, `data_r`=8'hFF.
- Write 8'hC1 to FF46 with slave returning the low address byte: exactly 160 `oam_we` pulses; `oam_addr` 0..159 carries `oam_data` 8'h00..8'h9F; `bus_addr` runs C100..C19F; `bus_active` high for 644 cycles.
- Write 8'h40 (cart ROM region): first `bus_addr` is 16'h4000 appearing at cycle T0+5; `oam_we` for byte 0 is at T0+9.
- Write 8'h80, then 8'h81 after 50 bytes: `idx` restarts at 0 with `bus_addr` 16'h8100; total `oam_we` count is 50+160; `data_r` = 8'h81.
- Assert `reset` at byte 80: next cycle `bus_active`=0, no further `oam_we`, and `data_r`=8'hFF.
- Write 8'hE3: with `OAM_DMA_ECHO_CLAMP_EN` the first `bus_addr` is 16'hC300; without it the first `bus_addr` is 16'hE300.
